regbank_rr_arbiter: RTL and testbench
=====================================

Name: regbank_rr_arbiter

Overview:
- Round-robin arbiter and write sequencer for a small register bank built from async-reset, active-low-cleared D flip-flops.
- Shares the bank's single write port among NREQ requesters; provides one combinational read port.
- Sits between the control-path requesters and the storage bank; the bank itself lives inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width of each bank entry
- AW, 3, address width; bank depth = 2**AW

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  NREQ  write request per requester; level, held until granted
- wr_addr  input  NREQ*AW  flattened addresses; requester i at bits [i*AW +: AW]
- wr_data  input  NREQ*DW  flattened data; requester i at bits [i*DW +: DW]
- gnt  output  NREQ  one-hot, one-cycle acknowledge for the write just performed
- busy  output  1  high while state is WRITE
- rd_addr  input  AW  read address
- rd_data  output  DW  combinational read of bank[rd_addr]

Behaviour:
- Reset (asynchronous, reset=0): state=ARB, gnt=0, busy=0, all bank entries=0, last pointer=NREQ-1 so requester 0 has top priority. Reset asserted mid-WRITE aborts the write: no bank update, no gnt.
- States: ARB, WRITE.
- ARB: if req==0, stay in ARB. Otherwise pick the first set req scanning last+1, last+2, ... modulo NREQ.
  - At that edge, capture winner index, wr_addr and wr_data of the winner into holding registers.
  - Set gnt_r = one-hot(winner) and move to WRITE.
- WRITE: gnt = one-hot(winner) and busy=1 for exactly this one cycle.
  - At the closing edge: bank[held addr] <= held data, last <= winner, gnt <= 0, state <= ARB.
  - req is ignored during WRITE.
- Latency: req seen at edge k → gnt high during cycle k..k+1 → bank updated at edge k+1 → rd_data reflects new value from edge k+1.
- Throughput: at most one write per 2 cycles.
- Handshake:
  - Requester drops req in the cycle after it sees gnt. If req is still high at the next ARB sample, it is arbitrated again with lowest priority (rotation guarantees no starvation).
  - Inputs changing after capture have no effect on the pending write.
- Simultaneous requests: exactly one winner per ARB cycle; gnt is never multi-hot.
- Same address written by consecutive grants: last write wins.
- rd_addr == held address during WRITE: rd_data returns the old value (unless REGBANK_BYPASS_EN is defined).
- Out-of-range: none; AW fully decodes the bank.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined: during WRITE, if rd_addr equals the held address, rd_data = held data (write-through forwarding). Otherwise rd_data = bank[rd_addr].
- Undefined: rd_data is always bank[rd_addr]. New data appears only after the write edge.

Test Plan:
- Reset check: hold reset=0, then release → gnt=0, busy=0, rd_data=0 for rd_addr 0..7; async assert mid-WRITE → gnt falls immediately and the target entry stays 0.
- Single write: req=4'b0010, wr_addr[1]=5, wr_data[1]=8'hA5 → gnt=4'b0010 for exactly one cycle, busy=1 in that cycle; rd_addr=5 gives 8'hA5 from the next cycle.
- All four request together, each dropping req after its gnt, addresses 0..3, data 8'h10..8'h13 → gnt sequence 0001,0010,0100,1000 at 2-cycle spacing; bank[0..3]=10,11,12,13.
- Fairness: req0 held permanently high with req2 also high → grants alternate 0,2,0,2; req2 is never skipped.
- Collision: requester 1 writes addr 6 = 8'h11, then requester 3 writes addr 6 = 8'h33 → final bank[6]=8'h33.
- Bypass: rd_addr=6 during a WRITE of 8'h77 to addr 6 → rd_data=8'h77 in the WRITE cycle with REGBANK_BYPASS_EN defined; the old value without it.

Source files
------------

// File: rtl/regbank_rr_arbiter.sv
// Round-robin write arbiter in front of a small async-cleared register bank.
// Optional REGBANK_BYPASS_EN forwards held write data to the read port during WRITE.
module regbank_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    input  logic [AW-1:0]     rd_addr,
    output logic [DW-1:0]     rd_data
);

    localparam int IW    = $clog2(NREQ);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        ARB   = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win_q, win_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [DW-1:0]   bank_q [DEPTH];

    logic            found;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            we;

    // Rotating priority scan starting just after the last winner
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Mux out the winner's address and data
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == IW'(i)) begin
                sel_addr = wr_addr[i*AW +: AW];
                sel_data = wr_data[i*DW +: DW];
            end
        end
    end

    // Next-state and capture logic for the ARB/WRITE sequencer
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        addr_d  = addr_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        we      = 1'b0;
        unique case (state_q)
            ARB: begin
                if (found) begin
                    win_d   = sel;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_d[i] = (sel == IW'(i));
                    end
                    state_d = WRITE;
                end
            end
            WRITE: begin
                we      = 1'b1;
                last_d  = win_q;
                gnt_d   = '0;
                state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    // Sequencer state and holding registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
            last_q  <= IW'(NREQ - 1);
            win_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
        end
    end

    // Storage bank, written on the closing edge of WRITE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (we) begin
            bank_q[addr_q] <= data_q;
        end
    end

    // Combinational read port
    always_comb begin
        rd_data = bank_q[rd_addr];
`ifdef REGBANK_BYPASS_EN
        if (state_q == WRITE && rd_addr == addr_q) begin
            rd_data = data_q;
        end
`endif
    end

    assign gnt  = gnt_q;
    assign busy = (state_q == WRITE);

endmodule

// File: tb/tb_regbank_rr_arbiter.sv
// Scoreboard bench for regbank_rr_arbiter: expected grants are queued
// when requests are driven and checked as gnt pulses appear.
module tb_regbank_rr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 3;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      rd_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = -1;
    bit gap_en = 0;
    logic [NREQ-1:0] hold_mask = '0;
    logic [NREQ-1:0] prev_g = '0;
    logic [NREQ-1:0] sb[$];
    logic [NREQ-1:0] e;

    regbank_rr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt     (gnt),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                      input string tag);
        @(negedge clk);
        rd_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk(tag, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        wr_addr[i*AW +: AW] = a;
        wr_data[i*DW +: DW] = d;
    endtask

    // Grant monitor: pops the scoreboard on every gnt pulse
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            prev_g = '0;
        end else begin
            if (prev_g != '0) chk("gnt_1cyc", gnt, 0);
            if (gnt != '0) begin
                if (sb.size() == 0) begin
                    chk("gnt_unexp", gnt, 0);
                end else begin
                    e = sb.pop_front();
                    chk("gnt_seq", gnt, e);
                end
                chk("busy_wr", busy, 1);
                if (gap_en) begin
                    if (last_cyc >= 0) chk("gnt_gap", cyc - last_cyc, 2);
                    last_cyc = cyc;
                end
                req = req & (hold_mask | ~gnt);
            end
            prev_g = gnt;
        end
    end

    initial begin
        reset   = 1'b0;
        req     = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_gnt", gnt, 0);
        chk("rel_busy", busy, 0);
        for (int a = 0; a < 8; a++) rd(AW'(a), 8'h00, "rst_bank");

        // single write from requester 1
        @(negedge clk);
        set_req(1, 3'd5, 8'hA5);
        sb.push_back(4'b0010);
        req = 4'b0010;
        wait_empty("single_to");
        rd(3'd5, 8'hA5, "single_rd");
        chk("idle_busy", busy, 0);

        // async reset in the middle of a WRITE
        @(negedge clk);
        set_req(3, 3'd7, 8'hEE);
        sb.push_back(4'b1000);
        req = 4'b1000;
        begin
            int n;
            n = 0;
            while (n < 50) begin
                @(negedge clk);
                #1;
                if (busy) break;
                n++;
            end
            chk("abort_busy_seen", busy, 1);
        end
        reset = 1'b0;
        #1;
        chk("abort_gnt", gnt, 0);
        chk("abort_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req = '0;
        chk("abort_sb", sb.size(), 0);
        sb.delete();
        rd(3'd7, 8'h00, "abort_bank");
        rd(3'd5, 8'h00, "abort_clr");

        // all four request together
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), DW'(8'h10 + i));
        sb.push_back(4'b0001);
        sb.push_back(4'b0010);
        sb.push_back(4'b0100);
        sb.push_back(4'b1000);
        gap_en = 1;
        last_cyc = -1;
        req = 4'b1111;
        wait_empty("all4_to");
        for (int a = 0; a < 4; a++) rd(AW'(a), DW'(8'h10 + a), "all4_bank");

        // fairness: req0 and req2 held permanently
        @(negedge clk);
        last_cyc = -1;
        set_req(0, 3'd4, 8'h40);
        set_req(2, 3'd4, 8'h42);
        hold_mask = 4'b0101;
        sb.push_back(4'b0001);
        sb.push_back(4'b0100);
        sb.push_back(4'b0001);
        sb.push_back(4'b0100);
        req = 4'b0101;
        wait_empty("fair_to");
        #1;
        req = '0;
        hold_mask = '0;
        gap_en = 0;
        rd(3'd4, 8'h42, "fair_bank");

        // collision: two writes to addr 6, last one wins
        @(negedge clk);
        set_req(1, 3'd6, 8'h11);
        sb.push_back(4'b0010);
        req = 4'b0010;
        wait_empty("col1_to");
        rd(3'd6, 8'h11, "col1_bank");
        set_req(3, 3'd6, 8'h33);
        sb.push_back(4'b1000);
        req = 4'b1000;
        wait_empty("col2_to");
        rd(3'd6, 8'h33, "col2_bank");

        // read of the target address during WRITE
        @(negedge clk);
        rd_addr = 3'd6;
        set_req(0, 3'd6, 8'h77);
        sb.push_back(4'b0001);
        req = 4'b0001;
        begin
            int n;
            n = 0;
            while (n < 50) begin
                @(negedge clk);
                #1;
                if (busy) break;
                n++;
            end
            chk("byp_busy_seen", busy, 1);
        end
`ifdef REGBANK_BYPASS_EN
        chk("byp_rd", rd_data, 8'h77);
`else
        chk("byp_rd", rd_data, 8'h33);
`endif
        wait_empty("byp_to");
        rd(3'd6, 8'h77, "byp_after");
        repeat (4) @(negedge clk);
        chk("end_sb", sb.size(), 0);
        chk("end_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
